niosii_jtag_cmd_bridge: RTL and testbench

System-clock side of the Nios II JTAG debug path. It synchronises the update-DR and update-IR strobes arriving from the TCK domain and captures the shift register and instruction register on each update-DR. Each capture is queued as a command in a parametrised FIFO with a valid/ready handshake. It replaces the fixed-width, unbuffered take_action decode with a generic width/depth bridge and adds overflow reporting.

---
 rtl/niosii_dbg_pkg.sv | 22 ++
 rtl/niosii_jtag_cmd_bridge_if.sv | 20 ++
 rtl/niosii_sync_edge.sv | 31 +++
 rtl/niosii_jtag_cmd_bridge.sv | 115 +++++++++++
 tb/tb_niosii_jtag_cmd_bridge.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/niosii_dbg_pkg.sv
// rtl/niosii_dbg_pkg.sv - shared widths, IR codes and command layout for the Nios II JTAG debug path
package niosii_dbg_pkg;

  localparam int DEF_SR_W        = 38;
  localparam int DEF_IR_W        = 2;
  localparam int DEF_ACT_BIT     = 34;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  // Default-width command; the bridge declares the same layout at its own widths.
  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic                action;
    logic [DEF_SR_W-1:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/niosii_jtag_cmd_bridge_if.sv
// rtl/niosii_jtag_cmd_bridge_if.sv - command queue head handshake between bridge and consumer
interface niosii_jtag_cmd_bridge_if
  import niosii_dbg_pkg::*;
#(
  parameter int SR_W = DEF_SR_W,
  parameter int IR_W = DEF_IR_W
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic            cmd_action;

  modport master (output cmd_valid, output cmd_ir, output cmd_data, output cmd_action,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_ir, input  cmd_data, input  cmd_action,
                  output cmd_ready);

endinterface

// File: rtl/niosii_sync_edge.sv
// rtl/niosii_sync_edge.sv - strobe synchroniser with arming and registered rising-edge pulse
module niosii_sync_edge
  import niosii_dbg_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;

  // fill_q marks which stages hold a real sample since reset, so a strobe held
  // high across reset release never looks like a rising edge. The compare uses
  // the last two stages so the registered pulse lands just before the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      fill_q <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      pulse  <= sync_q[STAGES-2] & ~sync_q[STAGES-1] & fill_q[STAGES-1];
    end
  end

endmodule

// File: rtl/niosii_jtag_cmd_bridge.sv
// rtl/niosii_jtag_cmd_bridge.sv - captures JTAG update-DR/IR into a command FIFO on the system clock
module niosii_jtag_cmd_bridge
  import niosii_dbg_pkg::*;
#(
  parameter int SR_W        = DEF_SR_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [SR_W-1:0]               sr,
  input  logic                          ovf_clr,
  niosii_jtag_cmd_bridge_if.master      cmd,
  output logic [SR_W-1:0]               jdo,
  output logic [IR_W-1:0]               ir_cur,
  output logic                          ir_update,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic            action;
    logic [SR_W-1:0] data;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          udr_p;
  logic          uir_p;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  niosii_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .strobe (vs_udr),
    .pulse  (udr_p)
  );

  niosii_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_edge (
    .clk    (clk),
    .rst_n  (reset_n),
    .strobe (vs_uir),
    .pulse  (uir_p)
  );

  // A full queue still accepts a capture when the head leaves in the same cycle.
  assign full    = (count == DEPTH_C);
  assign do_pop  = cmd.cmd_valid & cmd.cmd_ready;
  assign do_push = udr_p & (~full | do_pop);
  assign drop    = udr_p & ~do_push;

  assign head           = mem[rd_ptr];
  assign cmd.cmd_valid  = (count != '0);
  assign cmd.cmd_ir     = cmd.cmd_valid ? head.ir     : '0;
  assign cmd.cmd_action = cmd.cmd_valid ? head.action : 1'b0;
  assign cmd.cmd_data   = cmd.cmd_valid ? head.data   : '0;

  assign fifo_count = count;
  assign ir_update  = uir_p;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {ir_in, sr[ACT_BIT], sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // jdo tracks every update-DR, including ones the queue had to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo      <= '0;
      ir_cur   <= '0;
      overflow <= 1'b0;
    end else begin
      if (udr_p) jdo <= sr;
      if (uir_p) ir_cur <= ir_in;
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_niosii_jtag_cmd_bridge.sv
// tb/tb_niosii_jtag_cmd_bridge.sv - self-checking bench for niosii_jtag_cmd_bridge
module tb_niosii_jtag_cmd_bridge;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int ACT   = 34;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            vs_udr = 1'b1;
  logic            vs_uir = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            ovf_clr = 1'b0;
  logic [SR_W-1:0] jdo;
  logic [IR_W-1:0] ir_cur;
  logic            ir_update;
  logic            overflow;
  logic [2:0]      fifo_count;

  int checks = 0;
  int errors = 0;

  niosii_jtag_cmd_bridge_if #(.SR_W(SR_W), .IR_W(IR_W)) cmd_if ();

  niosii_jtag_cmd_bridge #(
    .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs_udr     (vs_udr),
    .vs_uir     (vs_uir),
    .ir_in      (ir_in),
    .sr         (sr),
    .ovf_clr    (ovf_clr),
    .cmd        (cmd_if),
    .jdo        (jdo),
    .ir_cur     (ir_cur),
    .ir_update  (ir_update),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a capture takes effect two edges after the first high
  // sample, provided the sample before it (since reset) was low.
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic            act;
    logic [SR_W-1:0] data;
  } mcmd_t;

  mcmd_t           mq[$];
  logic [3:0]      uh = '0;
  logic [3:0]      ih = '0;
  int              ne = 0;
  logic [SR_W-1:0] m_jdo = '0;
  logic [IR_W-1:0] m_ircur = '0;
  logic            m_ovf = 1'b0;
  logic            m_irupd = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        uh = '0; ih = '0; ne = 0;
        m_jdo = '0; m_ircur = '0; m_ovf = 1'b0; m_irupd = 1'b0;
      end else begin
        bit pop, push, rise_u, rise_i;
        ne++;
        uh = {uh[2:0], vs_udr};
        ih = {ih[2:0], vs_uir};
        rise_u  = (ne >= 4) && uh[2] && !uh[3];
        rise_i  = (ne >= 4) && ih[2] && !ih[3];
        m_irupd = (ne >= 3) && ih[1] && !ih[2];
        pop  = (mq.size() > 0) && cmd_if.cmd_ready;
        push = rise_u && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({ir_in, sr[ACT], sr});
        if (rise_u && !push) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (rise_u) m_jdo = sr;
        if (rise_i) m_ircur = ir_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("sb_valid", 64'(cmd_if.cmd_valid), 64'(mq.size() > 0));
      chk("sb_count", 64'(fifo_count), 64'(mq.size()));
      if (mq.size() > 0) begin
        chk("sb_data", 64'(cmd_if.cmd_data), 64'(mq[0].data));
        chk("sb_ir", 64'(cmd_if.cmd_ir), 64'(mq[0].ir));
        chk("sb_action", 64'(cmd_if.cmd_action), 64'(mq[0].act));
      end
      chk("sb_jdo", 64'(jdo), 64'(m_jdo));
      chk("sb_ir_cur", 64'(ir_cur), 64'(m_ircur));
      chk("sb_ir_update", 64'(ir_update), 64'(m_irupd));
      chk("sb_overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // One update-DR; cmd_ready/ovf_clr optionally asserted only at the capture edge.
  task automatic udr_cmd(input logic [SR_W-1:0] d, input logic pop, input logic clr);
    @(posedge clk); #1;
    sr = d; vs_udr = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cmd_if.cmd_ready = pop; ovf_clr = clr;
    @(posedge clk); #1;
    cmd_if.cmd_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic drain_expect(input logic [SR_W-1:0] d);
    chk("drain_valid", 64'(cmd_if.cmd_valid), 64'd1);
    chk("drain_data", 64'(cmd_if.cmd_data), 64'(d));
    cmd_if.cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_ready = 1'b0;
  endtask

  typedef struct {
    logic [SR_W-1:0] sr;
    logic            pop;
    logic            clr;
    int              exp_count;
    logic            exp_ovf;
    logic [SR_W-1:0] exp_head;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{38'd1,    1'b0, 1'b0, 1, 1'b0, 38'd1};
    tbl[1]  = '{38'd2,    1'b0, 1'b0, 2, 1'b0, 38'd1};
    tbl[2]  = '{38'd3,    1'b0, 1'b0, 3, 1'b0, 38'd1};
    tbl[3]  = '{38'd4,    1'b0, 1'b0, 4, 1'b0, 38'd1};
    tbl[4]  = '{38'd5,    1'b0, 1'b0, 4, 1'b1, 38'd1};
    tbl[5]  = '{38'd6,    1'b0, 1'b1, 4, 1'b1, 38'd1};
    tbl[6]  = '{38'h11,   1'b0, 1'b0, 1, 1'b0, 38'h11};
    tbl[7]  = '{38'h12,   1'b0, 1'b0, 2, 1'b0, 38'h11};
    tbl[8]  = '{38'h13,   1'b0, 1'b0, 3, 1'b0, 38'h11};
    tbl[9]  = '{38'h14,   1'b0, 1'b0, 4, 1'b0, 38'h11};
    tbl[10] = '{38'h15,   1'b1, 1'b0, 4, 1'b0, 38'h12};
    cmd_if.cmd_ready = 1'b0;

    // Strobe already high at reset release must not capture.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_hi_count", 64'(fifo_count), 64'd0);
    chk("rst_hi_valid", 64'(cmd_if.cmd_valid), 64'd0);
    vs_udr = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    sr = 38'h04_0000_1234; vs_udr = 1'b1;
    @(posedge clk); #1;
    chk("lat_k", 64'(cmd_if.cmd_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_k1", 64'(cmd_if.cmd_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_k2_valid", 64'(cmd_if.cmd_valid), 64'd1);
    chk("lat_k2_action", 64'(cmd_if.cmd_action), 64'd1);
    chk("lat_k2_data", 64'(cmd_if.cmd_data), 64'h04_0000_1234);
    @(posedge clk); #1;
    vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drain_expect(38'h04_0000_1234);
    chk("first_empty", 64'(cmd_if.cmd_valid), 64'd0);

    for (int i = 0; i < 6; i++) begin
      udr_cmd(tbl[i].sr, tbl[i].pop, tbl[i].clr);
      chk("tbl_count", 64'(fifo_count), 64'(tbl[i].exp_count));
      chk("tbl_ovf", 64'(overflow), 64'(tbl[i].exp_ovf));
      chk("tbl_jdo", 64'(jdo), 64'(tbl[i].sr));
      chk("tbl_head", 64'(cmd_if.cmd_data), 64'(tbl[i].exp_head));
    end
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", 64'(overflow), 64'd0);
    for (int i = 1; i <= 4; i++) drain_expect(38'(i));
    chk("drain1_empty", 64'(cmd_if.cmd_valid), 64'd0);

    for (int i = 6; i < 11; i++) begin
      udr_cmd(tbl[i].sr, tbl[i].pop, tbl[i].clr);
      chk("tbl_count", 64'(fifo_count), 64'(tbl[i].exp_count));
      chk("tbl_ovf", 64'(overflow), 64'(tbl[i].exp_ovf));
      chk("tbl_jdo", 64'(jdo), 64'(tbl[i].sr));
      chk("tbl_head", 64'(cmd_if.cmd_data), 64'(tbl[i].exp_head));
    end
    for (int i = 2; i <= 5; i++) drain_expect(38'(32'h10 + i));
    chk("drain2_count", 64'(fifo_count), 64'd0);

    // Update-IR and update-DR in the same cycle.
    @(posedge clk); #1;
    ir_in = 2'b10; sr = 38'h2A; vs_uir = 1'b1; vs_udr = 1'b1;
    @(posedge clk); #1;
    chk("irupd_k", 64'(ir_update), 64'd0);
    @(posedge clk); #1;
    chk("irupd_k1", 64'(ir_update), 64'd1);
    @(posedge clk); #1;
    chk("irupd_k2", 64'(ir_update), 64'd0);
    chk("ir_cur", 64'(ir_cur), 64'd2);
    chk("both_cmd_ir", 64'(cmd_if.cmd_ir), 64'd2);
    chk("both_valid", 64'(cmd_if.cmd_valid), 64'd1);
    @(posedge clk); #1;
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drain_expect(38'h2A);

    // Reset with three queued commands and a strobe inside the synchroniser.
    for (int i = 0; i < 3; i++) udr_cmd(38'(32'h30 + i), 1'b0, 1'b0);
    @(posedge clk); #1;
    sr = 38'h3F; vs_udr = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_jdo", 64'(jdo), 64'd0);
    chk("arst_ir_cur", 64'(ir_cur), 64'd0);
    chk("arst_data", 64'(cmd_if.cmd_data), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("post_rst_count", 64'(fifo_count), 64'd0);
    chk("post_rst_jdo", 64'(jdo), 64'd0);

    // Randomized strobes, consumer backpressure and overflow clears.
    begin
      int  ph;
      bit  hi;
      int  bias;
      ph = 0;
      hi = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk); #1;
        bias = (((c / 400) % 2) == 0) ? 1 : 6;
        cmd_if.cmd_ready = ($urandom_range(0, 7) < bias);
        ovf_clr = ($urandom_range(0, 15) == 0);
        if (ph > 0) begin
          ph--;
        end else if (!hi) begin
          sr = 38'({$urandom(), $urandom()});
          ir_in = 2'($urandom_range(0, 3));
          vs_udr = ($urandom_range(0, 3) != 0);
          vs_uir = ($urandom_range(0, 2) == 0);
          hi = 1'b1;
          ph = $urandom_range(3, 5);
        end else begin
          vs_udr = 1'b0;
          vs_uir = 1'b0;
          hi = 1'b0;
          ph = $urandom_range(3, 6);
        end
      end
    end
    vs_udr = 1'b0; vs_uir = 1'b0; cmd_if.cmd_ready = 1'b0; ovf_clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
